// File: rtl/nco_waveform_gen.sv
// nco_waveform_gen: phase-accumulating NCO with four waveform modes.
//   Stage 1 forms the sample phase p = acc + phase_off and captures mode.
//   Stage 2 decodes the phase into sine (quarter-wave LUT), triangle,
//   sawtooth or square.
//   Optional stage 3 (NCO_AMP_SCALE_EN defined) scales by amp.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   en           issue one sample on this edge
//   sync_clr     treat accumulator as zero on this edge (phase realign)
//   fcw          unsigned phase increment
//   phase_off    phase offset added to the accumulator
//   mode         00 sine, 01 triangle, 10 sawtooth, 11 square
//   amp          unsigned amplitude (only with NCO_AMP_SCALE_EN)
//   wave_out     signed two's-complement sample
//   out_valid    wave_out carries a new sample
//   wrap         one-cycle pulse on accumulator carry-out
module nco_waveform_gen #(
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned LUT_AW  = 6,
  parameter int unsigned OUT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sync_clr,
  input  logic [PHASE_W-1:0] fcw,
  input  logic [PHASE_W-1:0] phase_off,
  input  logic [1:0]         mode,
`ifdef NCO_AMP_SCALE_EN
  input  logic [OUT_W-1:0]   amp,
`endif
  output logic [OUT_W-1:0]   wave_out,
  output logic               out_valid,
  output logic               wrap
);

  localparam int unsigned MAG_W = OUT_W - 1;
  localparam int unsigned LUT_N = 1 << LUT_AW;
  // Only the top phase bits feed any decoder; keep just those in stage 1.
  localparam int unsigned SEL_W = (LUT_AW > MAG_W) ? LUT_AW : MAG_W;
  localparam int unsigned TOP_W = SEL_W + 2;
  localparam int unsigned SHIFT = PHASE_W - TOP_W;
  localparam real         PI    = 3.14159265358979323846;

  localparam logic [1:0] MODE_SINE = 2'b00;
  localparam logic [1:0] MODE_TRI  = 2'b01;
  localparam logic [1:0] MODE_SAW  = 2'b10;

  // Quarter-wave entry i, sampled at the centre of its bin so that the
  // ~a mirror in the second quadrant lands on exactly the same values.
  function automatic logic [MAG_W-1:0] lut_val(input int idx);
    real x;
    real term;
    real s;
    real v;
    x    = PI * real'(2 * idx + 1) / real'(1 << (LUT_AW + 2));
    term = x;
    s    = x;
    for (int k = 1; k < 12; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      s    = s + term;
    end
    v = s * real'((1 << MAG_W) - 1) + 0.5;
    return MAG_W'($rtoi(v));
  endfunction

  logic [MAG_W-1:0] lut [LUT_N];

  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
    localparam logic [MAG_W-1:0] LV = lut_val(gi);
    assign lut[gi] = LV;
  end

  // Accumulator and carry
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] acc_base;
  logic [PHASE_W:0]   acc_sum;

  assign acc_base = sync_clr ? '0 : acc;
  assign acc_sum  = {1'b0, acc_base} + {1'b0, fcw};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= en & acc_sum[PHASE_W];
      if (en)            acc <= acc_sum[PHASE_W-1:0];
      else if (sync_clr) acc <= '0;
    end
  end

  // Stage 1: sample phase and mode
  logic [TOP_W-1:0] p1;
  logic [1:0]       m1;
  logic             v1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1 <= '0;
      m1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= en;
      if (en) begin
        p1 <= TOP_W'((acc_base + phase_off) >> SHIFT);
        m1 <= mode;
      end
    end
  end

  // Waveform decode
  logic [1:0]       q;
  logic [LUT_AW-1:0] a;
  logic [MAG_W-1:0] r;
  logic [MAG_W-1:0] mag;
  logic [OUT_W-1:0] mag_ext;
  logic             saw;
  logic [OUT_W-1:0] wave_c;

  assign q = p1[TOP_W-1 -: 2];
  assign a = p1[TOP_W-3 -: LUT_AW];
  assign r = p1[TOP_W-3 -: MAG_W];

  // Sine, triangle and square share a magnitude plus sign-from-q[1] path.
  always_comb begin
    mag    = '1;
    saw    = 1'b0;
    wave_c = '0;
    case (m1)
      MODE_SINE: mag = q[0] ? lut[~a] : lut[a];
      MODE_TRI:  mag = q[0] ? ~r : r;
      MODE_SAW:  saw = 1'b1;
      default:   mag = '1;
    endcase
    mag_ext = {1'b0, mag};
    if (saw)       wave_c = p1[TOP_W-1 -: OUT_W];
    else if (q[1]) wave_c = ~mag_ext + OUT_W'(1);
    else           wave_c = mag_ext;
  end

`ifdef NCO_AMP_SCALE_EN
  localparam int unsigned      PROD_W = 2 * OUT_W + 1;
  localparam logic [OUT_W-1:0] UNITY  = OUT_W'(1 << MAG_W);

  logic [OUT_W-1:0]         w2;
  logic                     v2;
  logic [OUT_W-1:0]         amp_c;
  logic signed [PROD_W-1:0] prod;

  assign amp_c = (amp > UNITY) ? UNITY : amp;
  assign prod  = PROD_W'($signed(w2)) * PROD_W'($signed({1'b0, amp_c}));

  // Stage 2: raw sample; stage 3: amplitude scale with floor shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w2        <= '0;
      v2        <= 1'b0;
      wave_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      v2        <= v1;
      out_valid <= v2;
      if (v1) w2       <= wave_c;
      if (v2) wave_out <= OUT_W'(prod >>> MAG_W);
    end
  end
`else
  // Stage 2: output register, holds across en gaps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wave_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) wave_out <= wave_c;
    end
  end
`endif

endmodule

// File: tb/tb_nco_waveform_gen.sv
// Directed bench for nco_waveform_gen (default build, or with
// NCO_AMP_SCALE_EN defined for the amplitude-scale variant).
module tb_nco_waveform_gen;

`ifdef NCO_AMP_SCALE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sync_clr = 1'b0;
  logic [15:0] fcw = 16'h0100;
  logic [15:0] phase_off = 16'h0000;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  amp = 8'd128;
  logic [7:0]  wave_out;
  logic        out_valid;
  logic        wrap;

  int checks = 0;
  int errors = 0;
  int wrap_cnt = 0;
  int out_n = 0;

  nco_waveform_gen dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sync_clr  (sync_clr),
    .fcw       (fcw),
    .phase_off (phase_off),
    .mode      (mode),
`ifdef NCO_AMP_SCALE_EN
    .amp       (amp),
`endif
    .wave_out  (wave_out),
    .out_valid (out_valid),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (wrap === 1'b1) wrap_cnt++;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] wv();
    return 32'($signed(wave_out));
  endfunction

  // One sync_clr+en edge restarts the stream at phase phase_off
  task automatic restart(input logic [1:0] m);
    mode     = m;
    en       = 1'b1;
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    repeat (LAT - 1) tick();
    out_n = 0;
  endtask

  task automatic advance_to(input int n);
    while (out_n < n) begin
      tick();
      out_n++;
    end
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_wave", wv(), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_wrap", 32'(wrap), 0);

    // Sine, fcw=0x0100, latency from first en edge
    rst = 1'b0;
    en  = 1'b1;
    tick();
    chk("lat_valid_early", 32'(out_valid), 0);
    repeat (LAT - 1) tick();
    chk("lat_valid", 32'(out_valid), 1);
    chk("sine_n0", wv(), 2);
    out_n    = 0;
    wrap_cnt = 0;
    advance_to(63);  chk("sine_n63", wv(), 127);
    advance_to(64);  chk("sine_n64", wv(), 127);
    advance_to(128); chk("sine_n128", wv(), -2);
    advance_to(192); chk("sine_n192", wv(), -127);
    advance_to(256); chk("wrap_count", wrap_cnt, 1);

    // Asynchronous reset mid-stream
    advance_to(260);
    #2 rst = 1'b1;
    #1;
    chk("arst_wave", wv(), 0);
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_wrap", 32'(wrap), 0);
    tick();
    rst = 1'b0;
    repeat (LAT) tick();
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_wave", wv(), 2);

    // Triangle
    restart(2'b01);
    chk("tri_n0", wv(), 0);
    advance_to(63);  chk("tri_n63", wv(), 126);
    advance_to(64);  chk("tri_n64", wv(), 127);
    advance_to(128); chk("tri_n128", wv(), 0);
    advance_to(192); chk("tri_n192", wv(), -127);

    // Sawtooth and a mid-stream switch to square
    restart(2'b10);
    advance_to(127); chk("saw_n127", wv(), 127);
    advance_to(128); chk("saw_n128", wv(), -128);
    advance_to(130);
    mode = 2'b11;
    advance_to(131); chk("switch_old_mode", wv(), -125);
    advance_to(132); chk("switch_new_mode", wv(), -127);

    // Square
    restart(2'b11);
    advance_to(127); chk("sqr_n127", wv(), 127);
    advance_to(128); chk("sqr_n128", wv(), -127);

    // sync_clr at a non-zero acc, phase_off=0x4000, fcw=0xE000
    mode      = 2'b00;
    phase_off = 16'h4000;
    fcw       = 16'hE000;
    sync_clr  = 1'b1;
    tick();
    chk("sync_wrap", 32'(wrap), 0);
    sync_clr = 1'b0;
    tick();
    chk("post_sync_wrap", 32'(wrap), 1);
    repeat (LAT - 2) tick();
    chk("sync_s0", wv(), 127);
    tick(); chk("sync_s1", wv(), 91);
    tick(); chk("sync_s2", wv(), 2);

    // en gap of 3 edges on a sawtooth (sample n reads back as n)
    fcw       = 16'h0100;
    phase_off = 16'h0000;
    restart(2'b10);
    advance_to(20);
    en = 1'b0;
    for (int t = 1; t <= LAT + 3; t++) begin
      tick();
      if (t == 3) en = 1'b1;
      if (t < LAT) begin
        out_n++;
        chk("gap_valid_pre", 32'(out_valid), 1);
        chk("gap_wave_pre", wv(), out_n);
      end else if (t < LAT + 3) begin
        chk("gap_valid_low", 32'(out_valid), 0);
        chk("gap_wave_hold", wv(), out_n);
      end else begin
        out_n++;
        chk("gap_valid_resume", 32'(out_valid), 1);
        chk("gap_wave_resume", wv(), out_n);
      end
    end

`ifdef NCO_AMP_SCALE_EN
    // Amplitude scaling
    amp = 8'd64;
    restart(2'b00);
    advance_to(64);  chk("amp64_peak", wv(), 63);
    advance_to(192); chk("amp64_trough", wv(), -64);
    amp = 8'd200;
    restart(2'b00);
    advance_to(64);  chk("amp200_peak", wv(), 127);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
